// File: rtl/cmn_rst_seq.sv
// cmn_rst_seq: reset sequencer.
// Synchronises the incoming asynchronous reset, then releases NUM_CH active-low
// reset outputs one at a time in index order, with GAP_CYC cycles between
// enabled channels. A warm reset can be requested from software once the
// sequence has finished.
// Optional build macro CMN_RST_SEQ_STATS_EN adds the warm_cnt / last_len
// statistics outputs.
module cmn_rst_seq #(
    parameter int NUM_CH      = 4,
    parameter int SYNC_STAGES = 2,
    parameter int HOLD_CYC    = 8,
    parameter int GAP_CYC     = 4,
    parameter int LEN_W       = 8,
    localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] ch_en,
    input  logic              sw_rst_req,
    input  logic [LEN_W-1:0]  sw_rst_len,
    output logic [NUM_CH-1:0] rst_out_n,
    output logic              seq_busy,
    output logic              seq_done,
    output logic [CH_W-1:0]   cur_ch
`ifdef CMN_RST_SEQ_STATS_EN
    ,
    output logic [15:0]       warm_cnt,
    output logic [LEN_W-1:0]  last_len
`endif
);

    // One counter serves every phase; it must hold the longest phase without wrapping.
    localparam int LEN_MAX  = 1 << LEN_W;
    localparam int HG_MAX   = (HOLD_CYC > GAP_CYC) ? HOLD_CYC : GAP_CYC;
    localparam int CNT_MAX  = (HG_MAX > LEN_MAX) ? HG_MAX : LEN_MAX;
    localparam int CNT_W    = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        ST_SYNC    = 3'd0,
        ST_HOLD    = 3'd1,
        ST_RELEASE = 3'd2,
        ST_DONE    = 3'd3,
        ST_SWRST   = 3'd4
    } state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [NUM_CH-1:0]      en_q, en_d;
    logic [LEN_W-1:0]       len_q, len_d;
    logic [CH_W-1:0]        cur_ch_q, cur_ch_d;
    logic [NUM_CH-1:0]      rst_out_q, rst_out_d;

    logic [CH_W:0]          first_en;
    logic [CH_W:0]          next_en;
    logic                   enter_rel;
    logic                   warm_acc;

    // Lowest set bit of en at or above index 'from'; MSB of the result flags "found".
    function automatic logic [CH_W:0] find_en(input logic [NUM_CH-1:0] en, input int from);
        logic            found;
        logic [CH_W-1:0] idx;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (!found && (i >= from) && en[i]) begin
                found = 1'b1;
                idx   = CH_W'(i);
            end
        end
        return {found, idx};
    endfunction

    // Set one bit of a channel vector selected by a channel index.
    function automatic logic [NUM_CH-1:0] set_ch(input logic [NUM_CH-1:0] vec,
                                                 input logic [CH_W-1:0]   idx);
        logic [NUM_CH-1:0] res;
        res = vec;
        for (int i = 0; i < NUM_CH; i++) begin
            if (i == int'(idx)) begin
                res[i] = 1'b1;
            end
        end
        return res;
    endfunction

    // Reset synchroniser: shifts a 1 in once rst_n is released.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign first_en = find_en(ch_en, 0);
    assign next_en  = find_en(en_q, int'(cur_ch_q) + 1);
    assign warm_acc = (state_q == ST_DONE) && sw_rst_req;

    // Sequencer next-state: phase counting, channel walk and warm-reset entry.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        en_d      = en_q;
        len_d     = len_q;
        cur_ch_d  = cur_ch_q;
        rst_out_d = rst_out_q;
        enter_rel = 1'b0;

        case (state_q)
            ST_SYNC: begin
                if (sync_q[SYNC_STAGES-1]) begin
                    // With no hold time the first release coincides with leaving SYNC.
                    if (HOLD_CYC == 0) begin
                        enter_rel = 1'b1;
                    end else begin
                        state_d = ST_HOLD;
                        cnt_d   = '0;
                    end
                end
            end

            ST_HOLD: begin
                if (cnt_q == CNT_W'(HOLD_CYC - 1)) begin
                    enter_rel = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            ST_RELEASE: begin
                // The channel in cur_ch_q has already been released; look for the next one.
                if (!next_en[CH_W]) begin
                    state_d  = ST_DONE;
                    cur_ch_d = '0;
                end else if (cnt_q == CNT_W'(GAP_CYC - 1)) begin
                    rst_out_d = set_ch(rst_out_q, next_en[CH_W-1:0]);
                    cur_ch_d  = next_en[CH_W-1:0];
                    cnt_d     = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            ST_DONE: begin
                if (sw_rst_req) begin
                    state_d   = ST_SWRST;
                    rst_out_d = '0;
                    cnt_d     = '0;
                    // A zero length still gives a one-cycle pulse.
                    len_d     = (sw_rst_len == '0) ? LEN_W'(1) : sw_rst_len;
                end
            end

            ST_SWRST: begin
                if (cnt_q == (CNT_W'(len_q) - CNT_W'(1))) begin
                    if (HOLD_CYC == 0) begin
                        enter_rel = 1'b1;
                    end else begin
                        state_d = ST_HOLD;
                        cnt_d   = '0;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            default: begin
                state_d = ST_SYNC;
                cnt_d   = '0;
            end
        endcase

        // Entering RELEASE: latch the enables and release the first enabled channel
        // on the same edge. Disabled channels are skipped without spending cycles.
        if (enter_rel) begin
            state_d  = ST_RELEASE;
            en_d     = ch_en;
            cnt_d    = '0;
            cur_ch_d = first_en[CH_W] ? first_en[CH_W-1:0] : '0;
            if (first_en[CH_W]) begin
                rst_out_d = set_ch(rst_out_q, first_en[CH_W-1:0]);
            end
        end
    end

    // Sequencer state and output registers; rst_n forces every output into reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_SYNC;
            cnt_q     <= '0;
            en_q      <= '0;
            len_q     <= '0;
            cur_ch_q  <= '0;
            rst_out_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            en_q      <= en_d;
            len_q     <= len_d;
            cur_ch_q  <= cur_ch_d;
            rst_out_q <= rst_out_d;
        end
    end

    assign rst_out_n = rst_out_q;
    assign seq_busy  = (state_q != ST_DONE);
    assign seq_done  = (state_q == ST_DONE);
    assign cur_ch    = (state_q == ST_RELEASE) ? cur_ch_q : '0;

`ifdef CMN_RST_SEQ_STATS_EN
    logic [15:0]      warm_cnt_q;
    logic [LEN_W-1:0] last_len_q;

    // Accepted warm-reset statistics; only a real rst_n clears them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            warm_cnt_q <= '0;
            last_len_q <= '0;
        end else if (warm_acc) begin
            if (warm_cnt_q != 16'hFFFF) begin
                warm_cnt_q <= warm_cnt_q + 16'd1;
            end
            last_len_q <= sw_rst_len;
        end
    end

    assign warm_cnt = warm_cnt_q;
    assign last_len = last_len_q;
`else
    // Without statistics the acceptance strobe has no consumer.
    logic unused_warm_acc;
    assign unused_warm_acc = warm_acc;
`endif

endmodule

// File: tb/tb_cmn_rst_seq.sv
// Directed bench for cmn_rst_seq: power-on sequence, channel skipping,
// warm reset (normal, zero length, dropped request) and an asynchronous
// rst_n glitch; a second instance covers NUM_CH=1 / HOLD_CYC=0 / SYNC_STAGES=3.
module tb_cmn_rst_seq;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic [3:0] ch_en;
    logic       sw_rst_req;
    logic [7:0] sw_rst_len;
    logic [3:0] rst_out_n;
    logic       seq_busy, seq_done;
    logic [1:0] cur_ch;

    logic [0:0] b_ch_en;
    logic       b_req;
    logic [7:0] b_len;
    logic [0:0] b_rst_out_n;
    logic       b_busy, b_done;
    logic [0:0] b_cur_ch;

`ifdef CMN_RST_SEQ_STATS_EN
    logic [15:0] warm_cnt;
    logic [7:0]  last_len;
    logic [15:0] b_warm_cnt;
    logic [7:0]  b_last_len;
`endif

    cmn_rst_seq u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ch_en      (ch_en),
        .sw_rst_req (sw_rst_req),
        .sw_rst_len (sw_rst_len),
        .rst_out_n  (rst_out_n),
        .seq_busy   (seq_busy),
        .seq_done   (seq_done),
        .cur_ch     (cur_ch)
`ifdef CMN_RST_SEQ_STATS_EN
        ,
        .warm_cnt   (warm_cnt),
        .last_len   (last_len)
`endif
    );

    cmn_rst_seq #(
        .NUM_CH      (1),
        .SYNC_STAGES (3),
        .HOLD_CYC    (0),
        .GAP_CYC     (4),
        .LEN_W       (8)
    ) u_dut_b (
        .clk        (clk),
        .rst_n      (rst_n),
        .ch_en      (b_ch_en),
        .sw_rst_req (b_req),
        .sw_rst_len (b_len),
        .rst_out_n  (b_rst_out_n),
        .seq_busy   (b_busy),
        .seq_done   (b_done),
        .cur_ch     (b_cur_ch)
`ifdef CMN_RST_SEQ_STATS_EN
        ,
        .warm_cnt   (b_warm_cnt),
        .last_len   (b_last_len)
`endif
    );

    int n_cmp  = 0;
    int n_fail = 0;

    int         rise [4];
    int         done_at;
    int         b_rise;
    int         b_done_at;
    logic [1:0] cc [0:63];
    logic [3:0] snap_out;
    logic       snap_busy;
    logic       snap_done;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Step 'stop-start' clock edges, numbering them start+1.., recording the
    // first cycle each output rises; optionally snapshot or inject a request.
    task automatic watch(input int start, input int stop, input int snap_c, input int inj_c);
        for (int i = 0; i < 4; i++) rise[i] = -1;
        done_at   = -1;
        b_rise    = -1;
        b_done_at = -1;
        for (int c = start + 1; c <= stop; c++) begin
            @(posedge clk);
            #1;
            sw_rst_req = 1'b0;
            for (int i = 0; i < 4; i++) begin
                if (rise[i] < 0 && rst_out_n[i]) rise[i] = c;
            end
            if (done_at < 0 && seq_done) done_at = c;
            if (b_rise < 0 && b_rst_out_n[0]) b_rise = c;
            if (b_done_at < 0 && b_done) b_done_at = c;
            cc[c] = cur_ch;
            if (c == snap_c) begin
                snap_out  = rst_out_n;
                snap_busy = seq_busy;
                snap_done = seq_done;
            end
            if (c == inj_c) begin
                sw_rst_req = 1'b1;
                sw_rst_len = 8'd3;
            end
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        ch_en      = 4'hF;
        sw_rst_req = 1'b0;
        sw_rst_len = 8'd0;
        b_ch_en    = 1'b1;
        b_req      = 1'b0;
        b_len      = 8'd0;
        snap_out   = 4'hX;
        snap_busy  = 1'bX;
        snap_done  = 1'bX;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_n_in_reset", 32'(rst_out_n), 32'h0);
        chk("busy_in_reset",      32'(seq_busy),  32'd1);
        chk("done_in_reset",      32'(seq_done),  32'd0);
        chk("cur_ch_in_reset",    32'(cur_ch),    32'd0);
        chk("b_out_in_reset",     32'(b_rst_out_n), 32'd0);
        chk("b_busy_in_reset",    32'(b_busy),    32'd1);

        // Power-on sequence, all channels enabled
        @(negedge clk);
        rst_n = 1'b1;
        watch(0, 30, -1, -1);
        chk("por_rise0", 32'(rise[0]), 32'd11);
        chk("por_rise1", 32'(rise[1]), 32'd15);
        chk("por_rise2", 32'(rise[2]), 32'd19);
        chk("por_rise3", 32'(rise[3]), 32'd23);
        chk("por_done",  32'(done_at), 32'd24);
        chk("por_cur_ch_c12", 32'(cc[12]), 32'd0);
        chk("por_cur_ch_c16", 32'(cc[16]), 32'd1);
        chk("por_cur_ch_c20", 32'(cc[20]), 32'd2);
        chk("por_busy_end",   32'(seq_busy), 32'd0);
        chk("por_cur_ch_end", 32'(cur_ch),   32'd0);
        chk("b_rise",    32'(b_rise),    32'd4);
        chk("b_done",    32'(b_done_at), 32'd5);

        // Warm reset, length 5
        sw_rst_req = 1'b1;
        sw_rst_len = 8'd5;
        watch(0, 40, 1, -1);
        chk("warm5_out_low", 32'(snap_out),  32'h0);
        chk("warm5_busy",    32'(snap_busy), 32'd1);
        chk("warm5_done",    32'(snap_done), 32'd0);
        chk("warm5_rise0", 32'(rise[0]), 32'd14);
        chk("warm5_rise1", 32'(rise[1]), 32'd18);
        chk("warm5_rise3", 32'(rise[3]), 32'd26);
        chk("warm5_seq_done", 32'(done_at), 32'd27);
`ifdef CMN_RST_SEQ_STATS_EN
        chk("warm5_warm_cnt", 32'(warm_cnt), 32'd1);
        chk("warm5_last_len", 32'(last_len), 32'd5);
`endif

        // Zero-length warm reset with ch_en=0101; request during RELEASE is dropped
        ch_en      = 4'b0101;
        sw_rst_req = 1'b1;
        sw_rst_len = 8'd0;
        watch(0, 40, 13, 12);
        chk("len0_rise0", 32'(rise[0]), 32'd10);
        chk("len0_rise2", 32'(rise[2]), 32'd14);
        chk("len0_rise1_never", 32'(rise[1]), 32'hFFFF_FFFF);
        chk("len0_rise3_never", 32'(rise[3]), 32'hFFFF_FFFF);
        chk("len0_seq_done",    32'(done_at), 32'd15);
        chk("drop_req_no_change", 32'(snap_out), 32'b0001);
        chk("skip_final_out",   32'(rst_out_n), 32'b0101);
`ifdef CMN_RST_SEQ_STATS_EN
        chk("len0_warm_cnt", 32'(warm_cnt), 32'd2);
        chk("len0_last_len", 32'(last_len), 32'd0);
`endif

        // Warm reset, then a half-cycle rst_n glitch just after ch1 release
        ch_en      = 4'hF;
        sw_rst_req = 1'b1;
        sw_rst_len = 8'd1;
        watch(0, 15, -1, -1);
        chk("pre_glitch_rise1", 32'(rise[1]), 32'd14);
        rst_n = 1'b0;
        #1;
        chk("glitch_out_low", 32'(rst_out_n), 32'h0);
        chk("glitch_busy",    32'(seq_busy),  32'd1);
        chk("glitch_cur_ch",  32'(cur_ch),    32'd0);
`ifdef CMN_RST_SEQ_STATS_EN
        chk("glitch_warm_cnt", 32'(warm_cnt), 32'd0);
`endif
        #3;
        rst_n = 1'b1;
        watch(0, 30, -1, -1);
        chk("restart_rise0", 32'(rise[0]), 32'd11);
        chk("restart_rise1", 32'(rise[1]), 32'd15);
        chk("restart_rise3", 32'(rise[3]), 32'd23);
        chk("restart_done",  32'(done_at), 32'd24);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
